// File: rtl/ram_arbiter_v_if.sv
// Bundle of requester handshakes and the shared RAM port seen by ram_arbiter_v.
// slave = arbiter view, master = requesters plus RAM view.
`timescale 1ns/1ps
interface ram_arbiter_v_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) ();
  logic              req0;
  logic              req1;
  logic              rw0;
  logic              rw1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic [1:0]        grant;
  logic [ADDR_W-1:0] bus_RAM_ADDRESS;
  logic              wire_RW;
  logic [DATA_W-1:0] bus_RAM_DATA_IN;
  logic [DATA_W-1:0] bus_RAM_DATA_OUT;

  modport slave (
    input  req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, bus_RAM_DATA_OUT,
    output ack0, ack1, rdata0, rdata1, grant, bus_RAM_ADDRESS, wire_RW, bus_RAM_DATA_IN
  );

  modport master (
    output req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, bus_RAM_DATA_OUT,
    input  ack0, ack1, rdata0, rdata1, grant, bus_RAM_ADDRESS, wire_RW, bus_RAM_DATA_IN
  );
endinterface

// File: rtl/ram_arbiter_v.sv
// Shares one synchronous RAM port between requester 0 (CPU) and requester 1, one access per 4 cycles.
// Ties go to requester 0 unless RAM_ARB_ROUND_ROBIN_EN is defined, which alternates winners.
`timescale 1ns/1ps
module ram_arbiter_v #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input logic            wire_clock,
  input logic            wire_reset_n,
  ram_arbiter_v_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              rw_q, rw_d;
  logic              is_wr_q, is_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              last_grant_q, last_grant_d;  // 1 = requester 1 was served last
  logic              pick1;

  // Winner selection, only consumed in IDLE
  always_comb begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
    pick1 = bus.req1 && (!bus.req0 || !last_grant_q);
`else
    pick1 = bus.req1 && !bus.req0;
`endif
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rw_d         = rw_q;
    is_wr_d      = is_wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    last_grant_d = last_grant_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          grant_d = pick1 ? 2'b10 : 2'b01;
          addr_d  = pick1 ? bus.addr1  : bus.addr0;
          wdata_d = pick1 ? bus.wdata1 : bus.wdata0;
          rw_d    = pick1 ? bus.rw1    : bus.rw0;
          is_wr_d = pick1 ? bus.rw1    : bus.rw0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // RAM samples address/write-enable on this edge; write enable lasts one cycle
        rw_d    = 1'b0;
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (grant_q[1]) begin
          ack1_d = 1'b1;
          if (!is_wr_q) rdata1_d = bus.bus_RAM_DATA_OUT;
        end else begin
          ack0_d = 1'b1;
          if (!is_wr_q) rdata0_d = bus.bus_RAM_DATA_OUT;
        end
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        // Ack cycle: requester drops or changes req; no arbitration here
        last_grant_d = grant_q[1];
        grant_d      = 2'b00;
        state_d      = S_IDLE;
      end
      default: begin
        grant_d = 2'b00;
        rw_d    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wire_clock or negedge wire_reset_n) begin
    if (!wire_reset_n) begin
      state_q      <= S_IDLE;
      grant_q      <= 2'b00;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rw_q         <= 1'b0;
      is_wr_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rw_q         <= rw_d;
      is_wr_q      <= is_wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.grant           = grant_q;
  assign bus.ack0            = ack0_q;
  assign bus.ack1            = ack1_q;
  assign bus.rdata0          = rdata0_q;
  assign bus.rdata1          = rdata1_q;
  assign bus.bus_RAM_ADDRESS = addr_q;
  assign bus.wire_RW         = rw_q;
  assign bus.bus_RAM_DATA_IN = wdata_q;

endmodule

// File: tb/tb_ram_arbiter_v.sv
// Directed bench for ram_arbiter_v with a synchronous RAM model behind the shared port.
`timescale 1ns/1ps
module tb_ram_arbiter_v;

  logic wire_clock   = 1'b0;
  logic wire_reset_n = 1'b1;

  ram_arbiter_v_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  ram_arbiter_v #(.ADDR_W(16), .DATA_W(16)) dut (
    .wire_clock   (wire_clock),
    .wire_reset_n (wire_reset_n),
    .bus          (bus)
  );

  always #5 wire_clock = ~wire_clock;

  // Synchronous RAM: samples address/write on the rising edge, data valid after it
  logic [15:0] mem [0:255] = '{0: 16'h1234, 16: 16'h0F0F, default: 16'h0000};
  always @(posedge wire_clock) begin
    if (bus.wire_RW) mem[bus.bus_RAM_ADDRESS[7:0]] <= bus.bus_RAM_DATA_IN;
    bus.bus_RAM_DATA_OUT <= mem[bus.bus_RAM_ADDRESS[7:0]];
  end

  int rw_hi_cnt = 0;
  int ack0_cnt  = 0;
  always @(posedge wire_clock) begin
    if (bus.wire_RW) rw_hi_cnt <= rw_hi_cnt + 1;
    if (bus.ack0)    ack0_cnt  <= ack0_cnt + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Starts at a falling edge with the arbiter idle; ends one falling edge after the ack
  task automatic run_access(input bit who, input bit wr, input logic [15:0] a,
                            input logic [15:0] d, input logic [15:0] exp_rd, input string tag);
    int n;
    int rw0_snap;
    bit seen;
    rw0_snap = rw_hi_cnt;
    if (!who) begin
      bus.req0 = 1'b1; bus.rw0 = wr; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = 1'b1; bus.rw1 = wr; bus.addr1 = a; bus.wdata1 = d;
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 16) begin
      @(negedge wire_clock);
      n++;
      if (n == 1) begin
        chk({tag, "_grant"}, {30'd0, bus.grant}, who ? 32'd2 : 32'd1);
        chk({tag, "_addr"}, {16'd0, bus.bus_RAM_ADDRESS}, {16'd0, a});
        chk({tag, "_rw"}, {31'd0, bus.wire_RW}, {31'd0, wr});
      end
      seen = who ? bus.ack1 : bus.ack0;
    end
    chk({tag, "_latency"}, n, 3);
    chk({tag, "_rdata"}, {16'd0, who ? bus.rdata1 : bus.rdata0}, {16'd0, exp_rd});
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge wire_clock);
    chk({tag, "_ack_drop"}, {30'd0, bus.ack1, bus.ack0}, 32'd0);
    chk({tag, "_grant_clr"}, {30'd0, bus.grant}, 32'd0);
    chk({tag, "_rw_cycles"}, rw_hi_cnt - rw0_snap, wr ? 32'd1 : 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] who_seq [0:7];
    int          pos_seq [0:7];
    int          k;
    int          a0_snap;
    int          rw_snap;

    bus.req0 = 1'b0; bus.rw0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.rw1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    for (int i = 0; i < 8; i++) begin
      who_seq[i] = '1;
      pos_seq[i] = -1;
    end

    // Reset values
    #1 wire_reset_n = 1'b0;
    @(negedge wire_clock);
    chk("rst_grant", {30'd0, bus.grant}, 32'd0);
    chk("rst_ack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
    chk("rst_rw", {31'd0, bus.wire_RW}, 32'd0);
    chk("rst_addr", {16'd0, bus.bus_RAM_ADDRESS}, 32'd0);
    chk("rst_din", {16'd0, bus.bus_RAM_DATA_IN}, 32'd0);
    chk("rst_rdata0", {16'd0, bus.rdata0}, 32'd0);
    chk("rst_rdata1", {16'd0, bus.rdata1}, 32'd0);
    @(negedge wire_clock);
    wire_reset_n = 1'b1;
    @(negedge wire_clock);

    // Requester 0 read of preloaded word
    run_access(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1234, "r0_read");

    // Requester 1 write then read back
    run_access(1'b1, 1'b1, 16'h00A5, 16'hBEEF, 16'h0000, "r1_write");
    chk("r1_write_mem", {16'd0, mem[8'hA5]}, 32'h0000BEEF);
    run_access(1'b1, 1'b0, 16'h00A5, 16'h0000, 16'hBEEF, "r1_read");
    chk("r1_read_rdata0_kept", {16'd0, bus.rdata0}, 32'h00001234);

    // Both requesting continuously
    bus.req0 = 1'b1; bus.rw0 = 1'b0; bus.addr0 = 16'h0000;
    bus.req1 = 1'b1; bus.rw1 = 1'b0; bus.addr1 = 16'h00A5;
    k = 0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge wire_clock);
      chk("cont_dual_ack", {31'd0, bus.ack0 & bus.ack1}, 32'd0);
      if (bus.ack0 || bus.ack1) begin
        if (k < 8) begin
          who_seq[k] = {31'd0, bus.ack1};
          pos_seq[k] = c;
        end
        k++;
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    chk("cont_ack_count", k, 6);
    for (int i = 0; i < 6; i++) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
      chk("cont_winner", who_seq[i], i % 2);
`else
      chk("cont_winner", who_seq[i], 0);
`endif
      chk("cont_ack_pos", pos_seq[i], 3 + 4 * i);
    end
    @(negedge wire_clock);
    chk("cont_idle_grant", {30'd0, bus.grant}, 32'd0);

    // Reset during ISSUE of a write
    a0_snap = ack0_cnt;
    bus.req0 = 1'b1; bus.rw0 = 1'b1; bus.addr0 = 16'h0010; bus.wdata0 = 16'h5555;
    @(negedge wire_clock);
    chk("rstw_issue_rw", {31'd0, bus.wire_RW}, 32'd1);
    chk("rstw_issue_grant", {30'd0, bus.grant}, 32'd1);
    #2 wire_reset_n = 1'b0;
    #1;
    chk("rstw_async_rw", {31'd0, bus.wire_RW}, 32'd0);
    chk("rstw_async_grant", {30'd0, bus.grant}, 32'd0);
    bus.req0 = 1'b0;
    repeat (3) @(negedge wire_clock);
    chk("rstw_mem_kept", {16'd0, mem[8'h10]}, 32'h00000F0F);
    chk("rstw_no_ack", ack0_cnt - a0_snap, 32'd0);
    chk("rstw_rdata0", {16'd0, bus.rdata0}, 32'd0);
    wire_reset_n = 1'b1;
    @(negedge wire_clock);

    // Request pulse that never sees an IDLE edge
    rw_snap = rw_hi_cnt;
    #1 bus.req0 = 1'b1; bus.rw0 = 1'b1; bus.addr0 = 16'h0077; bus.wdata0 = 16'hAAAA;
    #2 bus.req0 = 1'b0;
    @(negedge wire_clock);
    chk("pulse_grant", {30'd0, bus.grant}, 32'd0);
    chk("pulse_addr", {16'd0, bus.bus_RAM_ADDRESS}, 32'd0);
    @(negedge wire_clock);
    chk("pulse_grant2", {30'd0, bus.grant}, 32'd0);
    chk("pulse_no_rw", rw_hi_cnt - rw_snap, 32'd0);
    chk("pulse_mem", {16'd0, mem[8'h77]}, 32'd0);
    run_access(1'b1, 1'b0, 16'h00A5, 16'h0000, 16'hBEEF, "post_pulse_r1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter_v.md
# ram_arbiter_v

Two-port arbiter that shares the single synchronous program/data RAM port between the CPU (requester 0) and a second bus master (requester 1, e.g. video or debug DMA). Each requester issues a read or write with a level request and receives a one-cycle acknowledge with read data. The arbiter owns `bus_RAM_ADDRESS`, `wire_RW` and `bus_RAM_DATA_IN`, and sequences every access through a fixed four-state cycle so the RAM sees stable address, control and data.

## Interface
- `ADDR_W`, 16, address width of RAM and both requesters
- `DATA_W`, 16, data word width

- `wire_clock`  in  1  system clock, all state on rising edge
- `wire_reset_n`  in  1  reset, asynchronous, active-low
- `req0` / `req1`  in  1  access request, level; held until matching ack
- `rw0` / `rw1`  in  1  1 = write, 0 = read; stable while req high
- `addr0` / `addr1`  in  ADDR_W  access address; stable while req high
- `wdata0` / `wdata1`  in  DATA_W  write data; stable while req high
- `ack0` / `ack1`  out  1  one-cycle completion pulse
- `rdata0` / `rdata1`  out  DATA_W  read data, valid from ack cycle until next read by same requester
- `grant`  out  2  one-hot current owner, 00 when idle
- `bus_RAM_ADDRESS`  out  ADDR_W  RAM address
- `wire_RW`  out  1  RAM write enable, 1 = write
- `bus_RAM_DATA_IN`  out  DATA_W  RAM write data
- `bus_RAM_DATA_OUT`  in  DATA_W  RAM read data, valid one cycle after the RAM samples the address

## Operation
- States: IDLE, ISSUE, CAPTURE, RELEASE.
- IDLE: if no req, stay. If one req, grant it. If both, resolve per Configuration. On grant: register winner's addr/rw/wdata onto `bus_RAM_ADDRESS`/`wire_RW`/`bus_RAM_DATA_IN`, set `grant`, go ISSUE.
- ISSUE: RAM samples address and `wire_RW` at the edge leaving ISSUE; write commits there. On that edge clear `wire_RW` to 0 and go CAPTURE.
- CAPTURE: on leaving edge, if access was a read, load `bus_RAM_DATA_OUT` into winner's `rdata`. Assert winner's `ack` and go RELEASE. Writes leave `rdata` unchanged.
- RELEASE: on leaving edge, drop `ack`, clear `grant`, record winner in `last_grant`, go IDLE. No arbitration occurs in RELEASE. This gives the requester the ack cycle to drop or change `req`.
- `bus_RAM_ADDRESS` and `bus_RAM_DATA_IN` hold their last value when idle.
- The non-granted requester's `rdata` and `ack` are never disturbed.
- Request changes while not granted are allowed. A request dropped before grant is simply not served.
- A requester changing addr/rw/wdata after grant is a protocol violation. The registered copies are used regardless.

## Timing
- Reset (async assert): state IDLE, `grant`=00, `ack0`=`ack1`=0, `wire_RW`=0, `bus_RAM_ADDRESS`=0, `bus_RAM_DATA_IN`=0, `rdata0`=`rdata1`=0, `last_grant`=1 (so requester 0 wins the first tie). Deassertion takes effect at the next clock edge.
- Reset mid-access: the access is abandoned, `wire_RW` drops to 0 immediately, and no ack is issued. A write is lost if reset arrives before the ISSUE→CAPTURE edge.
- Grant sampled at edge E0. RAM address valid after E0. Write commits at E1. Ack high between E2 and E3. Next arbitration at E4.
- Throughput: one access per 4 cycles. A continuously requesting single master is served every 4 cycles.
- `wire_RW` is high for exactly one cycle per write, never for reads.

## Configuration
- `RAM_ARB_ROUND_ROBIN_EN` defined: when both requests are high in IDLE, the requester not in `last_grant` wins. This strictly alternates under continuous contention.
- Not defined: fixed priority, requester 0 always wins ties. Requester 1 is served only in IDLE cycles with `req0` low. `last_grant` is still maintained but ignored.

## Test plan
- Reset, then `req0` read addr 0x0000 with RAM holding 0x1234: `bus_RAM_ADDRESS`=0x0000 after E0, `ack0` high E2–E3, `rdata0`=0x1234, `wire_RW` never 1.
- `req1` write addr 0x00A5 data 0xBEEF, then `req1` read 0x00A5: `wire_RW`=1 for exactly one cycle, read returns 0xBEEF via `rdata1`, `rdata0` unchanged.
- Both requests held continuously: with `RAM_ARB_ROUND_ROBIN_EN`, acks alternate ack0, ack1, ack0, … every 4 cycles. Without it, only `ack0` pulses while `req0` stays high.
- Assert `wire_reset_n`=0 in ISSUE of a write to 0x0010 with data 0x5555: `wire_RW` drops to 0 asynchronously, no ack, RAM[0x0010] unchanged, `grant`=00.
- `req0` raised then dropped before any IDLE edge: no grant, no RAM activity. A subsequent `req1` is served normally with 4-cycle latency.
